calc_sequencer: RTL

//  Sequences the shared add/sub datapath behind the keypad front end. Captures operands, operation and

---
 rtl/calc_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/calc_sequencer.sv
// Keypad calculator sequencer: captures operands/op from the key decoder and drives a
// bit-serial two's-complement add/sub, plus a memory register shared with the display.
module calc_sequencer #(
  parameter int WIDTH = 8,
  parameter bit SAT   = 1'b0
) (
  input  logic             Clock,
  input  logic             clearN,
  input  logic             clearIn,
  input  logic [WIDTH-1:0] numberA,
  input  logic             signedNumberA,
  input  logic [WIDTH-1:0] numberB,
  input  logic             signedNumberB,
  input  logic             operation,
  input  logic             signedOperation,
  input  logic [WIDTH-1:0] memoryOut,
  input  logic             signedMemory,
  input  logic             save_result,
  input  logic             calc_req,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             overflow,
  output logic             busy,
  output logic             dropped,
  output logic [WIDTH-1:0] memoryIn,
  output logic [1:0]       estate
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_reg, b_reg;
  logic             op_reg;
  logic [WIDTH-1:0] sh_a, sh_b, sh_r;
  logic             carry;
  logic [CW-1:0]    cnt;

  // A strobe coinciding with calc_req feeds the datapath directly.
  logic [WIDTH-1:0] a_eff, b_eff;
  logic             op_eff;
  assign a_eff  = signedNumberA   ? numberA   : a_reg;
  assign b_eff  = signedNumberB   ? numberB   : b_reg;
  assign op_eff = signedOperation ? operation : op_reg;

  logic             any_strobe, last_shift;
  logic             sum_bit, carry_out, ovf_now;
  logic [WIDTH-1:0] sum_word, sat_word;

  assign any_strobe = signedNumberA | signedNumberB | signedOperation | calc_req;
  assign last_shift = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
  assign sum_bit    = sh_a[0] ^ sh_b[0] ^ carry;
  assign carry_out  = (sh_a[0] & sh_b[0]) | (carry & (sh_a[0] ^ sh_b[0]));
  // On the final shift, carry is the carry into the MSB and sh_a[0] is the sign of A.
  assign ovf_now    = carry ^ carry_out;
  assign sum_word   = {sum_bit, sh_r[WIDTH-1:1]};
  assign sat_word   = sh_a[0] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};

  assign busy   = (state != IDLE);
  assign estate = state;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clock or negedge clearN) begin
    if (!clearN) state <= IDLE;
    else         state <= state_nxt;
  end

  // NOTE: next-state gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    if (clearIn) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (calc_req) state_nxt = SHIFT;
        SHIFT:   if (last_shift) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: the memory register is a single register, so it is cleared by clearN like everything else.
  always_ff @(posedge Clock or negedge clearN) begin
    if (!clearN) begin
      a_reg        <= '0;
      b_reg        <= '0;
      op_reg       <= 1'b0;
      sh_a         <= '0;
      sh_b         <= '0;
      sh_r         <= '0;
      carry        <= 1'b0;
      cnt          <= '0;
      result       <= '0;
      overflow     <= 1'b0;
      result_valid <= 1'b0;
      dropped      <= 1'b0;
      memoryIn     <= '0;
    end else begin
      result_valid <= 1'b0;
      dropped      <= 1'b0;

      if (clearIn) begin
        a_reg    <= '0;
        b_reg    <= '0;
        op_reg   <= 1'b0;
        result   <= '0;
        overflow <= 1'b0;
        cnt      <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (signedNumberA)   a_reg  <= numberA;
            if (signedNumberB)   b_reg  <= numberB;
            if (signedOperation) op_reg <= operation;
            if (calc_req) begin
              sh_a  <= a_eff;
              sh_b  <= b_eff ^ {WIDTH{op_eff}};
              carry <= op_eff;
              cnt   <= '0;
            end
          end
          SHIFT: begin
            sh_a    <= sh_a >> 1;
            sh_b    <= sh_b >> 1;
            sh_r    <= sum_word;
            carry   <= carry_out;
            cnt     <= cnt + CW'(1);
            dropped <= any_strobe;
            if (last_shift) begin
              result       <= (SAT && ovf_now) ? sat_word : sum_word;
              overflow     <= ovf_now;
              result_valid <= 1'b1;
            end
          end
          DONE:    dropped <= any_strobe;
          default: ;
        endcase
      end

      // Memory writes are accepted in every state and survive clearIn.
      if (signedMemory)     memoryIn <= memoryOut;
      else if (save_result) memoryIn <= result;
    end
  end

endmodule
